// File: rtl/sent_rx_fast_frame_assembler.sv
// SENT fast-channel frame assembler: collects status, data and CRC nibbles,
// hands the frame to an external CRC checker and publishes good frames.
module sent_rx_fast_frame_assembler #(
  parameter int CHECK_TIMEOUT = 4
) (
  input  logic        clk_rx,
  input  logic        reset_n_rx,
  input  logic        sync_i,
  input  logic [3:0]  nibble_i,
  input  logic        nibble_valid_i,
  input  logic        pulse_error_i,
  input  logic [1:0]  cfg_data_nibbles_i,
  output logic [2:0]  enable_crc_check_o,
  output logic [29:0] data_check_crc_o,
  input  logic        crc_check_done_i,
  input  logic        valid_data_fast_i,
  output logic [3:0]  status_o,
  output logic [23:0] data_fast_o,
  output logic        data_fast_valid_o,
  output logic        crc_error_o,
  output logic        frame_error_o
);

  localparam int TW = $clog2(CHECK_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_STATUS, S_DATA, S_CRC, S_CHECK
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    cfg_q, cfg_d;
  logic [1:0]    pcfg_q, pcfg_d;
  logic          pend_q, pend_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [3:0]    stat_q, stat_d;
  logic [23:0]   data_q, data_d;
  logic [3:0]    crc_q, crc_d;
  logic [3:0]    ostat_q, ostat_d;
  logic [23:0]   odata_q, odata_d;
  logic          dv_q, dv_d;
  logic          cerr_q, cerr_d;
  logic          ferr_q, ferr_d;
  logic          leave;
  logic          sync_ok;

  function automatic logic [2:0] nlen(input logic [1:0] c);
    unique case (c)
      2'b00:   nlen = 3'd3;
      2'b01:   nlen = 3'd4;
      default: nlen = 3'd6;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    cfg_d   = cfg_q;
    pcfg_d  = pcfg_q;
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    stat_d  = stat_q;
    data_d  = data_q;
    crc_d   = crc_q;
    ostat_d = ostat_q;
    odata_d = odata_q;
    dv_d    = 1'b0;
    cerr_d  = 1'b0;
    ferr_d  = 1'b0;
    leave   = 1'b0;
    sync_ok = sync_i && (cfg_data_nibbles_i != 2'b11);
    unique case (state_q)
      S_IDLE: begin
        if (sync_i) begin
          if (!sync_ok) begin
            ferr_d = 1'b1;
          end else begin
            cfg_d   = cfg_data_nibbles_i;
            cnt_d   = 3'd0;
            state_d = S_STATUS;
          end
        end
      end
      S_STATUS, S_DATA, S_CRC: begin
        if (pulse_error_i) begin
          ferr_d  = 1'b1;
          pend_d  = 1'b0;
          state_d = S_IDLE;
        end else if (sync_i) begin
          ferr_d = 1'b1;
          cnt_d  = 3'd0;
          if (sync_ok) begin
            cfg_d   = cfg_data_nibbles_i;
            state_d = S_STATUS;
          end else begin
            state_d = S_IDLE;
          end
        end else if (nibble_valid_i) begin
          if (state_q == S_STATUS) begin
            stat_d  = nibble_i;
            data_d  = 24'd0;
            cnt_d   = 3'd0;
            state_d = S_DATA;
          end else if (state_q == S_DATA) begin
            data_d = {data_q[19:0], nibble_i};
            cnt_d  = cnt_q + 3'd1;
            if (cnt_q + 3'd1 == nlen(cfg_q)) state_d = S_CRC;
          end else begin
            crc_d   = nibble_i;
            tmo_d   = '0;
            state_d = S_CHECK;
          end
        end
      end
      S_CHECK: begin
        if (pulse_error_i) begin
          ferr_d  = 1'b1;
          pend_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          // a sync here starts the next frame once the checker is done
          if (sync_ok) begin
            pend_d = 1'b1;
            pcfg_d = cfg_data_nibbles_i;
          end
          if (crc_check_done_i) begin
            leave = 1'b1;
            if (valid_data_fast_i) begin
              ostat_d = stat_q;
              odata_d = data_q;
              dv_d    = 1'b1;
            end else begin
              cerr_d = 1'b1;
            end
          end else if (tmo_q == TW'(CHECK_TIMEOUT - 1)) begin
            ferr_d = 1'b1;
            leave  = 1'b1;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
          if (leave) begin
            pend_d = 1'b0;
            cnt_d  = 3'd0;
            if (pend_q || sync_ok) begin
              cfg_d   = sync_ok ? cfg_data_nibbles_i : pcfg_q;
              state_d = S_STATUS;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_rx or negedge reset_n_rx) begin
    if (!reset_n_rx) begin
      state_q <= S_IDLE;
      cfg_q   <= 2'b00;
      pcfg_q  <= 2'b00;
      pend_q  <= 1'b0;
      cnt_q   <= 3'd0;
      tmo_q   <= '0;
      stat_q  <= 4'd0;
      data_q  <= 24'd0;
      crc_q   <= 4'd0;
      ostat_q <= 4'd0;
      odata_q <= 24'd0;
      dv_q    <= 1'b0;
      cerr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      pcfg_q  <= pcfg_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      stat_q  <= stat_d;
      data_q  <= data_d;
      crc_q   <= crc_d;
      ostat_q <= ostat_d;
      odata_q <= odata_d;
      dv_q    <= dv_d;
      cerr_q  <= cerr_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    enable_crc_check_o = 3'b000;
    data_check_crc_o   = 30'd0;
    if (state_q == S_CHECK) begin
      unique case (cfg_q)
        2'b00:   enable_crc_check_o = 3'b011;
        2'b01:   enable_crc_check_o = 3'b010;
        default: enable_crc_check_o = 3'b001;
      endcase
      data_check_crc_o = {2'b00, data_q, crc_q};
    end
  end

  assign status_o          = ostat_q;
  assign data_fast_o       = odata_q;
  assign data_fast_valid_o = dv_q;
  assign crc_error_o       = cerr_q;
  assign frame_error_o     = ferr_q;

endmodule

// File: tb/tb_sent_rx_fast_frame_assembler.sv
// Bench for the SENT fast frame assembler: directed scenarios plus random
// traffic compared every cycle against a frame-level model.
module tb_sent_rx_fast_frame_assembler;

  localparam int T = 4;

  logic        clk_rx = 1'b0;
  logic        reset_n_rx = 1'b0;
  logic        sync_i = 1'b0;
  logic [3:0]  nibble_i = 4'd0;
  logic        nibble_valid_i = 1'b0;
  logic        pulse_error_i = 1'b0;
  logic [1:0]  cfg = 2'b00;
  logic [2:0]  enable_crc_check_o;
  logic [29:0] data_check_crc_o;
  logic        crc_check_done_i = 1'b0;
  logic        valid_data_fast_i = 1'b0;
  logic [3:0]  status_o;
  logic [23:0] data_fast_o;
  logic        data_fast_valid_o;
  logic        crc_error_o;
  logic        frame_error_o;

  int errs = 0;
  int checks = 0;

  sent_rx_fast_frame_assembler #(.CHECK_TIMEOUT(T)) dut (
    .clk_rx(clk_rx),
    .reset_n_rx(reset_n_rx),
    .sync_i(sync_i),
    .nibble_i(nibble_i),
    .nibble_valid_i(nibble_valid_i),
    .pulse_error_i(pulse_error_i),
    .cfg_data_nibbles_i(cfg),
    .enable_crc_check_o(enable_crc_check_o),
    .data_check_crc_o(data_check_crc_o),
    .crc_check_done_i(crc_check_done_i),
    .valid_data_fast_i(valid_data_fast_i),
    .status_o(status_o),
    .data_fast_o(data_fast_o),
    .data_fast_valid_o(data_fast_valid_o),
    .crc_error_o(crc_error_o),
    .frame_error_o(frame_error_o)
  );

  always #5 clk_rx = ~clk_rx;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // frame-level model: nq holds status, data nibbles, CRC in arrival order
  bit         m_busy, m_chk, m_pend;
  int         m_n, m_age;
  logic [1:0] m_pcfg;
  logic [3:0] nq[$];
  logic [3:0] m_stat;
  logic [23:0] m_data;
  bit         m_dv, m_ce, m_fe;

  function automatic int nmap(input logic [1:0] c);
    return (c == 2'b00) ? 3 : (c == 2'b01) ? 4 : 6;
  endfunction

  function automatic logic [23:0] dval();
    logic [23:0] v = 24'd0;
    for (int i = 1; i <= m_n; i++) v = {v[19:0], nq[i]};
    return v;
  endfunction

  function automatic logic [2:0] ecode(input int n);
    return (n == 3) ? 3'b011 : (n == 4) ? 3'b010 : 3'b001;
  endfunction

  task automatic mreset();
    m_busy = 0; m_chk = 0; m_pend = 0; m_n = 3; m_age = 0;
    m_pcfg = 2'b00; nq.delete();
    m_stat = 4'd0; m_data = 24'd0;
    m_dv = 0; m_ce = 0; m_fe = 0;
  endtask

  task automatic mstep();
    bit leave;
    leave = 0;
    m_dv = 0; m_ce = 0; m_fe = 0;
    if (!m_busy) begin
      if (sync_i) begin
        if (cfg == 2'b11) m_fe = 1;
        else begin m_busy = 1; m_n = nmap(cfg); nq.delete(); end
      end
    end else if (m_chk) begin
      if (pulse_error_i) begin
        m_fe = 1; m_busy = 0; m_chk = 0; m_pend = 0; nq.delete();
      end else begin
        if (sync_i && cfg != 2'b11) begin m_pend = 1; m_pcfg = cfg; end
        if (crc_check_done_i) begin
          leave = 1;
          if (valid_data_fast_i) begin
            m_stat = nq[0]; m_data = dval(); m_dv = 1;
          end else m_ce = 1;
        end else if (m_age == T - 1) begin
          m_fe = 1; leave = 1;
        end else m_age++;
        if (leave) begin
          m_chk = 0; nq.delete();
          if (m_pend) m_n = nmap(m_pcfg);
          else m_busy = 0;
          m_pend = 0;
        end
      end
    end else begin
      if (pulse_error_i) begin
        m_fe = 1; m_busy = 0; nq.delete();
      end else if (sync_i) begin
        m_fe = 1; nq.delete();
        if (cfg == 2'b11) m_busy = 0;
        else m_n = nmap(cfg);
      end else if (nibble_valid_i) begin
        nq.push_back(nibble_i);
        if (nq.size() == m_n + 2) begin m_chk = 1; m_age = 0; end
      end
    end
  endtask

  initial begin
    logic [2:0]  e_en;
    logic [31:0] e_dcc;
    int s;
    mreset();
    forever begin
      @(negedge clk_rx);
      if (!reset_n_rx) mreset();
      e_en  = m_chk ? ecode(m_n) : 3'b000;
      e_dcc = m_chk ? {4'b0, dval(), nq[m_n + 1]} : 32'd0;
      chk("enable", {29'b0, enable_crc_check_o}, {29'b0, e_en});
      chk("data_check_crc", {2'b0, data_check_crc_o}, e_dcc);
      chk("status", {28'b0, status_o}, {28'b0, m_stat});
      chk("data_fast", {8'b0, data_fast_o}, {8'b0, m_data});
      chk("data_fast_valid", {31'b0, data_fast_valid_o}, {31'b0, m_dv});
      chk("crc_error", {31'b0, crc_error_o}, {31'b0, m_ce});
      chk("frame_error", {31'b0, frame_error_o}, {31'b0, m_fe});
      s = 32'(data_fast_valid_o) + 32'(crc_error_o) + 32'(frame_error_o);
      chk("pulse_excl", {31'b0, s <= 1}, 32'd1);
      if (reset_n_rx) mstep();
    end
  end

  task automatic drv(input bit s, input bit nv, input logic [3:0] nb,
                     input bit pe, input bit dn, input bit vl);
    sync_i = s; nibble_valid_i = nv; nibble_i = nb;
    pulse_error_i = pe; crc_check_done_i = dn; valid_data_fast_i = vl;
    @(posedge clk_rx);
    #2;
  endtask

  task automatic idle();
    drv(0, 0, 4'd0, 0, 0, 0);
  endtask

  task automatic nib(input logic [3:0] v);
    drv(0, 1, v, 0, 0, 0);
  endtask

  initial begin
    logic [3:0] f1[8] = '{4'h5, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA};
    logic [3:0] f2[5] = '{4'h0, 4'hF, 4'hE, 4'hD, 4'h7};
    logic [3:0] f3[6] = '{4'h1, 4'hA, 4'hB, 4'hC, 4'hD, 4'h3};
    repeat (3) @(posedge clk_rx);
    #2;
    chk("rst_enable", {29'b0, enable_crc_check_o}, 32'd0);
    chk("rst_dcc", {2'b0, data_check_crc_o}, 32'd0);
    chk("rst_data", {8'b0, data_fast_o}, 32'd0);
    chk("rst_status", {28'b0, status_o}, 32'd0);
    reset_n_rx = 1'b1;
    idle();

    cfg = 2'b10;
    drv(1, 0, 4'd0, 0, 0, 0);
    foreach (f1[i]) nib(f1[i]);
    chk("n6_enable", {29'b0, enable_crc_check_o}, 32'h1);
    chk("n6_dcc", {2'b0, data_check_crc_o}, 32'h0123456A);
    idle();
    chk("n6_enable_hold", {29'b0, enable_crc_check_o}, 32'h1);
    drv(0, 0, 4'd0, 0, 1, 1);
    chk("n6_valid", {31'b0, data_fast_valid_o}, 32'd1);
    chk("n6_data", {8'b0, data_fast_o}, 32'h123456);
    chk("n6_status", {28'b0, status_o}, 32'h5);
    idle();

    cfg = 2'b00;
    drv(1, 0, 4'd0, 0, 0, 0);
    foreach (f2[i]) nib(f2[i]);
    chk("n3_enable", {29'b0, enable_crc_check_o}, 32'h3);
    chk("n3_dcc", {2'b0, data_check_crc_o}, 32'h0000FED7);
    drv(0, 0, 4'd0, 0, 1, 0);
    chk("n3_crc_err", {31'b0, crc_error_o}, 32'd1);
    chk("n3_data_kept", {8'b0, data_fast_o}, 32'h123456);
    idle();

    cfg = 2'b01;
    drv(1, 0, 4'd0, 0, 0, 0);
    nib(4'h1); nib(4'hA); nib(4'hB);
    drv(1, 0, 4'd0, 0, 0, 0);
    chk("resync_ferr", {31'b0, frame_error_o}, 32'd1);
    foreach (f3[i]) nib(f3[i]);
    drv(0, 0, 4'd0, 0, 1, 1);
    chk("n4_data", {8'b0, data_fast_o}, 32'h00ABCD);
    chk("n4_valid", {31'b0, data_fast_valid_o}, 32'd1);
    idle();

    drv(1, 0, 4'd0, 0, 0, 0);
    foreach (f3[i]) nib(f3[i]);
    repeat (T - 1) begin
      idle();
      chk("tmo_wait_ferr", {31'b0, frame_error_o}, 32'd0);
      chk("tmo_wait_en", {29'b0, enable_crc_check_o}, 32'h2);
    end
    idle();
    chk("tmo_ferr", {31'b0, frame_error_o}, 32'd1);
    chk("tmo_en", {29'b0, enable_crc_check_o}, 32'd0);
    idle();

    cfg = 2'b00;
    drv(1, 0, 4'd0, 0, 0, 0);
    nib(4'h1); nib(4'h2);
    drv(0, 0, 4'd0, 1, 0, 0);
    chk("perr_ferr", {31'b0, frame_error_o}, 32'd1);
    drv(1, 0, 4'd0, 0, 0, 0);
    nib(4'h4); nib(4'h1); nib(4'h2); nib(4'h3);
    reset_n_rx = 1'b0;
    #1;
    chk("rstcrc_dcc", {2'b0, data_check_crc_o}, 32'd0);
    chk("rstcrc_data", {8'b0, data_fast_o}, 32'd0);
    chk("rstcrc_status", {28'b0, status_o}, 32'd0);
    chk("rstcrc_ferr", {31'b0, frame_error_o}, 32'd0);
    @(posedge clk_rx);
    #2;
    reset_n_rx = 1'b1;
    nib(4'h9);
    chk("rel_valid", {31'b0, data_fast_valid_o}, 32'd0);
    chk("rel_ferr", {31'b0, frame_error_o}, 32'd0);
    chk("rel_enable", {29'b0, enable_crc_check_o}, 32'd0);

    cfg = 2'b11;
    drv(1, 0, 4'd0, 0, 0, 0);
    chk("cfg11_ferr", {31'b0, frame_error_o}, 32'd1);
    chk("cfg11_en", {29'b0, enable_crc_check_o}, 32'd0);
    nib(4'h3);
    chk("cfg11_idle_en", {29'b0, enable_crc_check_o}, 32'd0);
    chk("cfg11_idle_ferr", {31'b0, frame_error_o}, 32'd0);

    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 999) == 0) begin
        reset_n_rx = 1'b0;
        @(posedge clk_rx);
        #2;
        reset_n_rx = 1'b1;
      end
      cfg = ($urandom_range(0, 49) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      drv($urandom_range(0, 39) == 0, $urandom_range(0, 1) == 1,
          4'($urandom_range(0, 15)), $urandom_range(0, 199) == 0,
          $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1);
    end
    repeat (T + 2) idle();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
